// File: rtl/pipe_pkg.sv
// Shared definitions for the integer pipeline control blocks:
// FSM state encoding, register-index width and the nop used by clearing latches.
package pipe_pkg;

    localparam int REG_W = 5;

    // addi x0, x0, 0 -- what a cleared pipeline latch presents downstream
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_BUSY = 2'd1,
        ST_MD_DONE = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags when an in-flight load writes a register that a
// younger instruction reads. x0 is never a hazard. Purely combinational so the
// forwarding unit can reuse it.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int RW      = REG_W
)(
    input  logic [NUM_SRC-1:0][RW-1:0] src,
    input  logic [NUM_SRC-1:0]         src_use,
    input  logic [RW-1:0]              rd,
    input  logic                       rd_load,
    output logic                       hazard
);

    logic [NUM_SRC-1:0] hit;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign hit[i] = src_use[i] && (src[i] == rd);
    end

    assign hazard = rd_load && (rd != '0) && (|hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the F/D, D/X and X/M pipeline latches: load-use stalls,
// redirect flushes and multi-cycle mult/div occupancy of X, with a timeout that
// aborts a mult/div that never answers.
// Optional macro PIPE_PERF_CNT_EN adds saturating stall/flush/md-busy counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int TO_W       = 7,
    parameter int CNT_W      = 32
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] d_rs1,
    input  logic [REG_W-1:0] d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic [REG_W-1:0] dx_rd,
    input  logic             dx_is_load,
    input  logic             dx_is_md,
    input  logic             x_redirect,
    input  logic             md_ready,
    output logic             pc_ena,
    output logic             fd_ena,
    output logic             fd_clr,
    output logic             dx_ena,
    output logic             dx_clr,
    output logic             xm_ena,
    output logic             xm_clr,
    output logic             md_start,
    output logic             md_err,
    output logic [1:0]       state_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_md
`endif
);

    if (TO_W < $clog2(MD_TIMEOUT)) begin : g_bad_to_w
        $error("TO_W too narrow to hold MD_TIMEOUT");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            md_err_q;
    logic            err_set;
    logic            lu_hazard;

    hazard_detect #(.NUM_SRC(2), .RW(REG_W)) u_hazard (
        .src     ({d_rs2, d_rs1}),
        .src_use ({d_use_rs2, d_use_rs1}),
        .rd      (dx_rd),
        .rd_load (dx_is_load),
        .hazard  (lu_hazard)
    );

    // State, timeout counter and sticky error register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            md_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (err_set) md_err_q <= 1'b1;
        end
    end

    // Next state plus latch enables/clears from the current state and hazards
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_set  = 1'b0;
        pc_ena   = 1'b0;
        fd_ena   = 1'b0;
        fd_clr   = 1'b0;
        dx_ena   = 1'b0;
        dx_clr   = 1'b0;
        xm_ena   = 1'b0;
        xm_clr   = 1'b0;
        md_start = 1'b0;
        if (reset) begin
            fd_clr  = 1'b1;
            dx_clr  = 1'b1;
            xm_clr  = 1'b1;
            state_d = ST_RUN;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (x_redirect) begin
                        // Two wrong-path instrs in F/D and D/X become nops
                        pc_ena = 1'b1;
                        fd_ena = 1'b1;
                        dx_ena = 1'b1;
                        xm_ena = 1'b1;
                        fd_clr = 1'b1;
                        dx_clr = 1'b1;
                    end else if (dx_is_md) begin
                        // Hold F/D and D/X; the md instr stays in X
                        md_start = 1'b1;
                        xm_ena   = 1'b1;
                        xm_clr   = 1'b1;
                        state_d  = ST_MD_BUSY;
                        cnt_d    = '0;
                    end else if (lu_hazard) begin
                        // One bubble into X while the load moves on to M
                        dx_ena = 1'b1;
                        dx_clr = 1'b1;
                        xm_ena = 1'b1;
                    end else begin
                        pc_ena = 1'b1;
                        fd_ena = 1'b1;
                        dx_ena = 1'b1;
                        xm_ena = 1'b1;
                    end
                end
                ST_MD_BUSY: begin
                    xm_ena = 1'b1;
                    xm_clr = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (md_ready) begin
                        state_d = ST_MD_DONE;
                    end else if (cnt_q == TO_LAST) begin
                        err_set = 1'b1;
                        dx_clr  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_MD_DONE: begin
                    // Result latches into X/M; rd is forwarded from M, so no
                    // hazard check against the departing md instr
                    pc_ena  = 1'b1;
                    fd_ena  = 1'b1;
                    dx_ena  = 1'b1;
                    xm_ena  = 1'b1;
                    state_d = ST_RUN;
                end
                default: begin
                    fd_clr  = 1'b1;
                    dx_clr  = 1'b1;
                    xm_clr  = 1'b1;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Error shows in the timeout cycle itself, then stays until reset
    assign md_err  = !reset && (md_err_q || err_set);
    assign state_o = reset ? 2'(ST_RUN) : 2'(state_q);

`ifdef PIPE_PERF_CNT_EN
    logic stall_evt, flush_evt, md_evt;
    logic [CNT_W-1:0] perf_stall_q, perf_flush_q, perf_md_q;

    assign flush_evt = (state_q == ST_RUN) && x_redirect;
    assign stall_evt = (state_q == ST_RUN) && !x_redirect && !dx_is_md && lu_hazard;
    assign md_evt    = (state_q == ST_MD_BUSY);

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_md_q    <= '0;
        end else begin
            if (stall_evt && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 1'b1;
            if (flush_evt && !(&perf_flush_q)) perf_flush_q <= perf_flush_q + 1'b1;
            if (md_evt && !(&perf_md_q))       perf_md_q    <= perf_md_q + 1'b1;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
    assign perf_md    = perf_md_q;
`endif

endmodule
